jt12_multi_acc: RTL and testbench

//  Time-multiplexed, multi-channel operator accumulator with per-channel stereo pan and mixdown.

---
 rtl/jt12_acc_pkg.sv | 43 ++++
 rtl/jt12_sat_add.sv | 23 ++
 rtl/jt12_multi_acc.sv | 209 ++++++++++++++++++++
 tb/tb_jt12_multi_acc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jt12_acc_pkg.sv
// Shared types and helpers for the multi-channel operator accumulator.
// Holds the mixer state encoding, pan bit positions and the sign-extend
// and clamp helpers, which work on 32-bit values with the width passed in.
package jt12_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Position of the left/right enable inside each channel's 2-bit pan field
  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  // Sign-extend the low w bits of x to 32 bits
  function automatic logic signed [31:0] sext(input logic [31:0] x, input int w);
    logic signed [31:0] t;
    t = $signed(x << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Clamp a signed value into the range of a w-bit signed number
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // True when x does not fit in a w-bit signed number
  function automatic logic ovf(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/jt12_sat_add.sv
// Signed W+W saturating adder: clamps to the most positive/negative W-bit
// value instead of wrapping, and flags when a clamp happened.
module jt12_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W:0] w_full;

  // One extra bit of headroom; overflow when the top two bits disagree
  always_comb begin
    w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    o_ovf  = w_full[W] ^ w_full[W-1];
    if (!o_ovf)         o_sum = w_full[W-1:0];
    else if (w_full[W]) o_sum = {1'b1, {(W-1){1'b0}}};
    else                o_sum = {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/jt12_multi_acc.sv
// Time-multiplexed operator accumulator with per-channel stereo pan mixdown.
// Each slot adds one operator output into its channel accumulator; a zero
// slot snapshots all channels and starts a serial mix (one channel per
// clk_en edge) that ends with a one-clock snd_vld pulse.
// Optional feature: define JT12_ACC_CLIP_EN to get a sticky o_clip flag set
// on any accumulator or final-mix saturation; otherwise o_clip is tied 0.
//
// Handshake: no back-pressure. o_snd_vld is a single-clock strobe meaning
// o_snd_l/o_snd_r have just been updated; the values hold until the next strobe.
module jt12_multi_acc
  import jt12_acc_pkg::*;
#(
  parameter  int WIN  = 14,
  parameter  int WACC = 16,
  parameter  int WMIX = 16,
  parameter  int NCH  = 6,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              i_rst,
  input  logic              i_clk,
  input  logic              i_clk_en,
  input  logic [WIN-1:0]    i_op_result,
  input  logic [CHW-1:0]    i_op_ch,
  input  logic              i_sum_en,
  input  logic              i_zero,
  input  logic [2*NCH-1:0]  i_pan,
  output logic [WMIX-1:0]   o_snd_l,
  output logic [WMIX-1:0]   o_snd_r,
  output logic              o_snd_vld,
  output logic              o_busy,
  output logic              o_clip,
  output logic [1:0]        o_dbg_state
);

  localparam int WML = WMIX + CHW;

  logic [WACC-1:0] r_acc  [NCH];
  logic [WACC-1:0] r_snap [NCH];
  state_t          r_state;
  state_t          w_state_nxt;
  logic [CHW-1:0]  r_idx;
  logic [WML-1:0]  r_ml;
  logic [WML-1:0]  r_mr;
  logic [WMIX-1:0] r_snd_l;
  logic [WMIX-1:0] r_snd_r;
  logic            r_vld;

  logic            w_ch_ok;
  logic [CHW-1:0]  w_ch_idx;
  logic [WACC-1:0] w_cur;
  logic [WACC-1:0] w_acc_sel;
  logic [WACC-1:0] w_acc_sum;
  logic            w_acc_ovf;
  logic [NCH-1:0]  w_pan_l;
  logic [NCH-1:0]  w_pan_r;
  logic [WML-1:0]  w_ml_term;
  logic [WML-1:0]  w_mr_term;
  logic [WML-1:0]  w_ml_sum;
  logic [WML-1:0]  w_mr_sum;
  logic            w_ml_ovf;
  logic            w_mr_ovf;
  logic [WMIX-1:0] w_snd_l_nxt;
  logic [WMIX-1:0] w_snd_r_nxt;
  logic            w_mix_ovf;

  for (genvar c = 0; c < NCH; c++) begin : g_pan
    assign w_pan_l[c] = i_pan[2*c + PAN_L];
    assign w_pan_r[c] = i_pan[2*c + PAN_R];
  end

  // Slot decode: out-of-range channels never touch an accumulator
  always_comb begin
    w_ch_ok   = int'(i_op_ch) < NCH;
    w_ch_idx  = w_ch_ok ? i_op_ch : '0;
    w_cur     = i_sum_en ? WACC'(sext(32'(i_op_result), WIN)) : '0;
    w_acc_sel = w_ch_ok ? r_acc[w_ch_idx] : '0;
  end

  jt12_sat_add #(.W(WACC)) u_acc_add (
    .i_a(w_acc_sel), .i_b(w_cur), .o_sum(w_acc_sum), .o_ovf(w_acc_ovf)
  );

  // Mix terms for the channel currently being visited
  always_comb begin
    w_ml_term = w_pan_l[r_idx] ? WML'(sext(32'(r_snap[r_idx]), WACC)) : '0;
    w_mr_term = w_pan_r[r_idx] ? WML'(sext(32'(r_snap[r_idx]), WACC)) : '0;
  end

  // Mix sums carry CHW guard bits so they cannot wrap; the clamp to WMIX
  // happens once, when the result is published
  jt12_sat_add #(.W(WML)) u_ml_add (
    .i_a(r_ml), .i_b(w_ml_term), .o_sum(w_ml_sum), .o_ovf(w_ml_ovf)
  );
  jt12_sat_add #(.W(WML)) u_mr_add (
    .i_a(r_mr), .i_b(w_mr_term), .o_sum(w_mr_sum), .o_ovf(w_mr_ovf)
  );

  // Final narrowing clamp from the guarded mix width to the output width
  always_comb begin
    w_snd_l_nxt = WMIX'(sat(sext(32'(r_ml), WML), WMIX));
    w_snd_r_nxt = WMIX'(sat(sext(32'(r_mr), WML), WMIX));
    w_mix_ovf   = ovf(sext(32'(r_ml), WML), WMIX) | ovf(sext(32'(r_mr), WML), WMIX);
  end

  // Accumulators and frame snapshot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_acc[c]  <= '0;
        r_snap[c] <= '0;
      end
    end else if (i_clk_en) begin
      if (i_zero) begin
        for (int c = 0; c < NCH; c++) begin
          r_snap[c] <= r_acc[c];
          r_acc[c]  <= (w_ch_ok && (i_op_ch == CHW'(c))) ? w_cur : '0;
        end
      end else if (w_ch_ok) begin
        r_acc[w_ch_idx] <= w_acc_sum;
      end
    end
  end

  // Mixer state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Mixer next state: a zero slot always restarts the mix
  always_comb begin
    w_state_nxt = r_state;
    if (i_clk_en) begin
      if (i_zero) begin
        w_state_nxt = MIX;
      end else begin
        case (r_state)
          MIX:     if (r_idx == CHW'(NCH - 1)) w_state_nxt = DONE;
          DONE:    w_state_nxt = IDLE;
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Mixer datapath: channel index, running sums, published outputs, strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_ml    <= '0;
      r_mr    <= '0;
      r_snd_l <= '0;
      r_snd_r <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (i_clk_en) begin
        if (i_zero) begin
          r_idx <= '0;
          r_ml  <= '0;
          r_mr  <= '0;
        end else begin
          case (r_state)
            MIX: begin
              r_ml  <= w_ml_sum;
              r_mr  <= w_mr_sum;
              r_idx <= r_idx + 1'b1;
            end
            DONE: begin
              r_snd_l <= w_snd_l_nxt;
              r_snd_r <= w_snd_r_nxt;
              r_vld   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_snd_l     = r_snd_l;
  assign o_snd_r     = r_snd_r;
  assign o_snd_vld   = r_vld;
  assign o_busy      = (r_state == MIX);
  assign o_dbg_state = r_state;

`ifdef JT12_ACC_CLIP_EN
  logic r_clip;

  // Sticky clip flag: any clamp while accumulating or publishing the mix
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clip <= 1'b0;
    end else if (i_clk_en && !i_zero) begin
      if ((w_ch_ok && w_acc_ovf) ||
          ((r_state == MIX) && (w_ml_ovf || w_mr_ovf)) ||
          ((r_state == DONE) && w_mix_ovf))
        r_clip <= 1'b1;
    end
  end

  assign o_clip = r_clip;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ^{w_acc_ovf, w_ml_ovf, w_mr_ovf, w_mix_ovf};
  assign o_clip = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_multi_acc.sv
// Directed bench for jt12_multi_acc (NCH=6, WIN=14, WACC=16, WMIX=16).
module tb_jt12_multi_acc;

  localparam int NCH = 6;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_clk_en;
  logic [13:0] i_op_result;
  logic [2:0]  i_op_ch;
  logic        i_sum_en;
  logic        i_zero;
  logic [11:0] i_pan;
  logic [15:0] o_snd_l;
  logic [15:0] o_snd_r;
  logic        o_snd_vld;
  logic        o_busy;
  logic        o_clip;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_clip_sat;

  jt12_multi_acc dut (
    .i_rst(i_rst), .i_clk(clk), .i_clk_en(i_clk_en),
    .i_op_result(i_op_result), .i_op_ch(i_op_ch), .i_sum_en(i_sum_en),
    .i_zero(i_zero), .i_pan(i_pan),
    .o_snd_l(o_snd_l), .o_snd_r(o_snd_r), .o_snd_vld(o_snd_vld),
    .o_busy(o_busy), .o_clip(o_clip), .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One slot on one clk_en edge; inputs return to an idle slot afterwards
  task automatic slot(input int ch, input int val, input bit en, input bit z);
    i_clk_en    = 1'b1;
    i_op_ch     = 3'(ch);
    i_op_result = 14'(val);
    i_sum_en    = en;
    i_zero      = z;
    @(posedge clk); #1;
    i_op_ch     = 3'd7;
    i_op_result = '0;
    i_sum_en    = 1'b0;
    i_zero      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(7, 0, 1'b0, 1'b0);
  endtask

  task automatic hold(input int n);
    i_clk_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called right after a zero slot: walk the mix and check the result edge
  task automatic run_mix(input string tag, input int exp_l, input int exp_r);
    chk({tag, "_busy"}, o_busy, 1);
    for (int i = 0; i < NCH; i++) begin
      idle(1);
      chk({tag, "_novld"}, o_snd_vld, 0);
    end
    chk({tag, "_done_busy"}, o_busy, 0);
    idle(1);
    chk({tag, "_vld"}, o_snd_vld, 1);
    chk({tag, "_l"}, $signed(o_snd_l), exp_l);
    chk({tag, "_r"}, $signed(o_snd_r), exp_r);
    idle(1);
    chk({tag, "_vld_drop"}, o_snd_vld, 0);
  endtask

  initial begin
`ifdef JT12_ACC_CLIP_EN
    exp_clip_sat = 1;
`else
    exp_clip_sat = 0;
`endif
    // Reset
    i_rst = 1'b1; i_clk_en = 1'b0; i_op_result = '0; i_op_ch = 3'd7;
    i_sum_en = 1'b0; i_zero = 1'b0; i_pan = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l", $signed(o_snd_l), 0);
    chk("rst_r", $signed(o_snd_r), 0);
    chk("rst_vld", o_snd_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_clip", o_clip, 0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic sum, all channels to both sides
    for (int i = 0; i < 4; i++) slot(0, 100, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) slot(3, -50, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t1", 300, 300);
    chk("t1_clip", o_clip, 0);

    // 2: positive clamp of one channel accumulator
    for (int i = 0; i < 10; i++) slot(1, 8191, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t2", 32767, 32767);
    chk("t2_clip", o_clip, exp_clip_sat);

    // 2b: negative clamp on two accumulators, then mix clamp
    for (int i = 0; i < 5; i++) slot(1, -8192, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) slot(2, -8192, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t2b", -32768, -32768);

    // 3: pan routing ch0 left only, ch1 right only
    i_pan = 12'h009;
    slot(0, 1000, 1'b1, 1'b0);
    slot(1, -2000, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t3", 1000, -2000);
    i_pan = 12'hFFF;

    // 4: second zero two edges after the first drops the first frame
    slot(2, 500, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    chk("t4_busy_a", o_busy, 1);
    slot(2, 123, 1'b1, 1'b0);
    chk("t4_novld_a", o_snd_vld, 0);
    slot(7, 0, 1'b0, 1'b1);
    chk("t4_hold_l", $signed(o_snd_l), 1000);
    run_mix("t4", 123, 123);

    // 5: sum_en=0 and out-of-range channel slots ignored; zero slot seeds next frame
    slot(0, 10, 1'b1, 1'b0);
    slot(0, 999, 1'b0, 1'b0);
    slot(7, 2222, 1'b1, 1'b0);
    slot(6, -3000, 1'b1, 1'b0);
    slot(5, -20, 1'b1, 1'b0);
    slot(7, 5, 1'b1, 1'b0);
    slot(5, 40, 1'b1, 1'b1);
    run_mix("t5", -10, -10);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t5_seed", 40, 40);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t5_clear", 0, 0);

    // clk_en low in DONE: exactly one strobe once enabled again
    slot(3, 77, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    idle(NCH);
    hold(3);
    chk("ce_wait_vld", o_snd_vld, 0);
    chk("ce_wait_l", $signed(o_snd_l), 0);
    idle(1);
    chk("ce_vld", o_snd_vld, 1);
    chk("ce_l", $signed(o_snd_l), 77);
    hold(1);
    chk("ce_vld_once", o_snd_vld, 0);
    hold(2);
    chk("ce_vld_stay", o_snd_vld, 0);

    // 6: asynchronous reset in MIX with clk_en low
    slot(0, 55, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    slot(4, 300, 1'b1, 1'b0);
    idle(1);
    hold(1);
    chk("t6_busy_pre", o_busy, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_l", $signed(o_snd_l), 0);
    chk("t6_r", $signed(o_snd_r), 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_vld", o_snd_vld, 0);
    chk("t6_clip", o_clip, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    slot(4, 1, 1'b1, 1'b0);
    slot(7, 0, 1'b0, 1'b1);
    run_mix("t6_after", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
